uart_tx_cfg: RTL
================

# uart_tx_cfg

Configurable, buffered UART transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them on `tx_pin` with compile-time data width, parity mode and stop-bit count. Queued frames go out back-to-back with no idle gap. It sits between the CPU's output port logic and the board TX pin, so the core no longer stalls for a full frame per character.

## Interface
Parameters:
- `CLK_FRE`, default 50: clock frequency in MHz.
- `BAUD_RATE`, default 9600: bit rate.
- `DATA_BITS`, default 8: data bits per frame. Legal values are 5 to 8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 16: power of 2, at least 2.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tx_data`  in  DATA_BITS: word to send.
- `tx_data_valid`  in  1: `tx_data` is valid.
- `tx_data_ready`  out  1: FIFO can accept a word.
- `tx_pin`  out  1: serial output, idle high.
- `busy`  out  1: a frame is on the line.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of words queued.
- `cts_n`  in  1: present only with `UART_TX_CTS_EN`.

## Operation
Derived constants and sizing:
- CYCLE = CLK_FRE*1000000/BAUD_RATE. CYCLE must be at least 2.
- The baud counter is $clog2(CYCLE) bits wide and counts 0 to CYCLE-1.
- Every bit on the line lasts exactly CYCLE clocks.

Frame format, in order:
- Start bit (0).
- DATA_BITS data bits, LSB first.
- Parity bit, only if PARITY != 0.
- STOP_BITS stop bits (1).

Parity:
- Even: parity = XOR of the data bits.
- Odd: parity = inverted XOR of the data bits.

FIFO:
- A write happens when `tx_data_valid` and `tx_data_ready` are both high at a clock edge.
- `tx_data_ready` = (`fifo_level` != FIFO_DEPTH). It is combinational from the registered level.
- A write and a pop in the same cycle leave `fifo_level` unchanged.
- A write attempted while full is dropped; the sender must hold the word.

State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: on an edge where `fifo_level` != 0 (and CTS is permitted). At that edge the head word is popped into the shift register and `tx_pin` is driven 0.
- START → DATA: on baud count CYCLE-1.
- DATA → DATA: the bit counter increments on each CYCLE-1. DATA ends when the bit counter = DATA_BITS-1 at CYCLE-1.
- DATA → PARITY, or → STOP if PARITY = 0.
- PARITY → STOP: on CYCLE-1.
- STOP: lasts STOP_BITS*CYCLE clocks. At its final clock:
  - if the FIFO is non-empty and CTS permits, pop and go to START, with `tx_pin` driven 0 on the next clock (no gap);
  - otherwise go to IDLE.
- `busy` = (state != IDLE).
- Illegal state codes go to IDLE with `tx_pin` = 1.

## Timing
- `tx_pin` is a register. It falls 1 clock after the edge that accepts a word into an empty FIFO on an idle line.
- Frame length is CYCLE*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) clocks exactly.
- `busy` rises on the same edge as the start bit and falls on the edge that ends the last stop bit, when no frame follows.
- `fifo_level` updates 1 clock after a write or pop.

Reset values:
- `tx_pin` = 1, `busy` = 0, `fifo_level` = 0, `tx_data_ready` = 1.
- FIFO pointers are 0 and state is IDLE.

Reset asserted mid-frame:
- `tx_pin` returns to 1 immediately (asynchronous) and queued words are discarded.
- After release, nothing is transmitted until a new write.

## Configuration
- `UART_TX_CTS_EN` defined:
  - Adds input `cts_n`, synchronised through 2 flops.
  - A frame may start (from IDLE or from STOP) only when the synchronised `cts_n` is 0.
  - A frame already started always completes.
  - A `cts_n` falling edge reaches the FSM 2 clocks later; `tx_pin` falls on the 3rd edge if data is queued.
- `UART_TX_CTS_EN` undefined:
  - No `cts_n` port.
  - Frames start whenever the FIFO is non-empty.

## Test plan
1. CLK_FRE=16, BAUD_RATE=1000000 (CYCLE=16), 8N1. Write 0xA5 → `tx_pin` low 1 clock after accept for 16 clocks, then 1,0,1,0,0,1,0,1 at 16 clocks each, then high 16 clocks. `busy` is high for exactly 160 clocks.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2. Write 0x35 → data 1,0,1,0,1,1,0, parity 0, two stop bits. Frame length is 176 clocks.
3. PARITY=1, write 0x00 → parity bit 1. Then write 0x01 → parity bit 0.
4. FIFO_DEPTH=4, hold valid for 6 consecutive clocks with words 0x10 to 0x15:
   - Words 0x10 to 0x14 are accepted (first popped at once).
   - `tx_data_ready` drops with `fifo_level` = 4.
   - 0x15 is accepted after the first frame ends.
   - All six frames are back-to-back; `tx_pin` never idles between them.
5. Drop `rst_n` during data bit 3 with 3 words queued → `tx_pin` = 1, `busy` = 0, `fifo_level` = 0 at once. Line stays high after release.
6. With `UART_TX_CTS_EN`: `cts_n` = 1, write 0x55 → no start bit for 1000 clocks. Drop `cts_n` → start bit on the 3rd clock. Raise `cts_n` mid-frame → frame completes.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: FIFO front end, compile-time data/parity/stop format.
// Define UART_TX_CTS_EN to add the cts_n hardware flow-control input.
module uart_tx_cfg #(
   parameter int CLK_FRE    = 50,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_BITS-1:0]        tx_data,
   input  logic                        tx_data_valid,
   output logic                        tx_data_ready,
   output logic                        tx_pin,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef UART_TX_CTS_EN
   ,
   input  logic                        cts_n
`endif
);

   localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int CNT_W = $clog2(CYCLE);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CYCLE - 1);
   localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   tx_q, tx_d;

   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]       level_q;
   logic [DATA_BITS-1:0]   head;
   logic                   head_par;
   logic                   push, pop, cts_ok, can_start, baud_end;

`ifdef UART_TX_CTS_EN
   logic cts_s1_q, cts_s2_q;

   // Synchroniser resets to "not clear to send" so nothing leaves before cts_n is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cts_s1_q <= 1'b1;
         cts_s2_q <= 1'b1;
      end else begin
         cts_s1_q <= cts_n;
         cts_s2_q <= cts_s1_q;
      end
   end

   assign cts_ok = ~cts_s2_q;
`else
   assign cts_ok = 1'b1;
`endif

   assign tx_data_ready = (level_q != LVL_FULL);
   assign push          = tx_data_valid && tx_data_ready;
   assign head          = mem_q[rd_ptr_q];
   assign head_par      = (^head) ^ (PARITY == 1);
   assign can_start     = (level_q != '0) && cts_ok;
   assign baud_end      = (baud_cnt_q == CNT_MAX);

   // NOTE: the storage array has no reset; only pointers and level decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_data;
   end

   // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_end ? '0 : baud_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_d       = tx_q;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            baud_cnt_d = '0;
            tx_d       = 1'b1;
            if (can_start) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = head_par;
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               bit_cnt_d = '0;
               tx_d      = shift_q[0];
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (bit_cnt_q == BIT_LAST) begin
                  stop_cnt_d = 1'b0;
                  if (PARITY != 0) begin
                     tx_d    = par_q;
                     state_d = S_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = S_STOP;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (baud_end) begin
               stop_cnt_d = 1'b0;
               tx_d       = 1'b1;
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               if (stop_cnt_q == STOP_LAST) begin
                  // Chain straight into the next start bit so queued frames leave no gap.
                  if (can_start) begin
                     pop     = 1'b1;
                     shift_d = head;
                     par_d   = head_par;
                     tx_d    = 1'b0;
                     state_d = S_START;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            baud_cnt_d = '0;
            tx_d       = 1'b1;
            state_d    = S_IDLE;
         end
      endcase
   end

   assign tx_pin     = tx_q;
   assign busy       = (state_q != S_IDLE);
   assign fifo_level = level_q;

endmodule
